// File: rtl/xs3_pkg.sv
// Shared constants, FSM state type and digit-validity helper for the
// Excess-3 to BCD decoder.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic xs3_digit_valid(input logic [3:0] code);
    return (code >= XS3_MIN) && (code <= XS3_MAX);
  endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Combinational single-digit Excess-3 to BCD decoder. Invalid codes decode
// to 0 with err set.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs3,
  output logic [3:0] bcd,
  output logic       err
);

  logic valid;

  always_comb begin
    valid = xs3_digit_valid(xs3);
    bcd   = valid ? (xs3 - XS3_OFFSET) : 4'd0;
    err   = ~valid;
  end

endmodule

// File: rtl/xs3_bcd_dec.sv
// Multi-digit Excess-3 to packed-BCD decoder, one digit per clock, MSD first.
// Define XS3_BIN_OUT_EN to add the out_bin port and its multiply-accumulate.
module xs3_bcd_dec
  import xs3_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_xs3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic [NDIGITS-1:0]     out_err_mask,
  output logic                   out_err
`ifdef XS3_BIN_OUT_EN
  ,
  output logic [BIN_W-1:0]       out_bin
`endif
);

  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t                 state_q, state_d;
  logic [4*NDIGITS-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4*NDIGITS-1:0]   bcd_q, bcd_d;
  logic [NDIGITS-1:0]     mask_q, mask_d;
`ifdef XS3_BIN_OUT_EN
  logic [BIN_W-1:0]       bin_q, bin_d;
`endif

  logic [3:0]             dig_bcd;
  logic                   dig_err;
  logic [NDIGITS-1:0]     dig_sel;
  logic                   last_digit;

  xs3_digit_dec u_digit_dec (
    .xs3 (sreg_q[4*NDIGITS-1 -: 4]),
    .bcd (dig_bcd),
    .err (dig_err)
  );

  // Digit position gi is written on the CONV edge where cnt == NDIGITS-1-gi.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_sel
      assign dig_sel[gi] = (cnt_q == CNT_W'(NDIGITS - 1 - gi));
    end
  endgenerate

  assign last_digit = (cnt_q == CNT_W'(NDIGITS - 1));

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    mask_d  = mask_q;
`ifdef XS3_BIN_OUT_EN
    bin_d   = bin_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_xs3;
          cnt_d   = '0;
          bcd_d   = '0;
          mask_d  = '0;
`ifdef XS3_BIN_OUT_EN
          bin_d   = '0;
`endif
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (dig_sel[i]) begin
            bcd_d[4*i +: 4] = dig_bcd;
            mask_d[i]       = dig_err;
          end
        end
        sreg_d = sreg_q << 4;
`ifdef XS3_BIN_OUT_EN
        bin_d  = bin_q * BIN_W'(10) + BIN_W'(dig_bcd);
`endif
        if (last_digit) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      mask_q  <= '0;
`ifdef XS3_BIN_OUT_EN
      bin_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      mask_q  <= mask_d;
`ifdef XS3_BIN_OUT_EN
      bin_q   <= bin_d;
`endif
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bcd      = bcd_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;
`ifdef XS3_BIN_OUT_EN
  assign out_bin      = bin_q;
`endif

endmodule

// File: doc/xs3_bcd_dec.md
Name: xs3_bcd_dec

Overview:
- Multi-digit Excess-3 to packed-BCD decoder; the reverse of the team's BCD-to-Excess-3 digit converter.
- Accepts one NDIGITS-digit Excess-3 word per transaction on a valid/ready handshake.
- Decodes one digit per clock, most-significant digit first.
- Returns packed BCD plus per-digit invalid-code flags on a second valid/ready handshake. Sits between XS3-coded arithmetic/display paths and BCD consumers.

Parameters:
- NDIGITS, 4, number of decimal digits per word (1..8).
- BIN_W, 14, width of the optional binary result; must be >= ceil(log2(10^NDIGITS)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word.
- in_xs3  input  4*NDIGITS  Excess-3 word. Nibble i is digit i; nibble 0 is the least significant.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_bcd  output  4*NDIGITS  packed BCD result, same nibble order as in_xs3.
- out_err_mask  output  NDIGITS  bit i set when digit i held an invalid XS3 code.
- out_err  output  1  OR-reduction of out_err_mask.
- out_bin  output  BIN_W  binary value of out_bcd. Present only with XS3_BIN_OUT_EN.

Behaviour:
- Single clock. Reset is synchronous and active-high on rst; all state updates on the rising edge of clk.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_bcd=0, out_err_mask=0, out_err=0, out_bin=0, digit counter=0, internal shift register=0.
- Digit decode:
  - Valid codes are 0011..1100; bcd = xs3 - 3, taken modulo 16 on 4 bits.
  - Codes 0000, 0001, 0010, 1101, 1110 and 1111 are invalid. The BCD nibble is forced to 0 and the matching mask bit is set.
- FSM, states IDLE, CONV, DONE:
  - IDLE: in_ready=1. On in_valid & in_ready, capture in_xs3 into the shift register, clear the result registers, clear cnt, and go to CONV.
  - CONV: in_ready=0. Each edge decodes the top nibble of the shift register. The decoded nibble goes into out_bcd position NDIGITS-1-cnt; the register shifts left 4 and cnt increments. The edge with cnt==NDIGITS-1 moves to DONE.
  - DONE: out_valid=1. out_bcd, out_err_mask, out_err and out_bin are held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid is high in the cycle after the NDIGITS-th edge following the accepting edge.
- Throughput: at most one word every NDIGITS+2 cycles. in_ready is low in CONV and DONE; there is no accept in the same cycle as a result is taken.
- Result outputs are registered. Their values may change during CONV and are meaningful only while out_valid=1.
- Boundary conditions:
  - in_valid during CONV or DONE is ignored; the upstream holds the word.
  - out_ready while not in DONE has no effect.
  - rst in any state (including mid-CONV or DONE with out_ready=0) returns to IDLE with reset values on the next edge; the in-flight word is discarded.
  - NDIGITS=1: CONV lasts one cycle.

Optional Feature:
- Macro: XS3_BIN_OUT_EN.
- Defined: out_bin port exists. Each CONV edge computes bin <= bin*10 + decoded_digit, truncated to BIN_W; invalid digits contribute 0. bin is cleared on accept and on reset, and is held in DONE.
- Undefined: no out_bin port, no multiply-accumulate logic; all other behaviour is identical.

Decomposition:
- Package xs3_pkg holds:
  - XS3_OFFSET=4'd3, XS3_MIN=4'd3, XS3_MAX=4'd12;
  - the state enum {IDLE, CONV, DONE};
  - a digit-valid function.
- One sub-module, xs3_digit_dec: combinational 4-bit XS3 in, 4-bit BCD plus invalid flag out. It is instanced once, on the top nibble of the shift register.

Test Plan:
- Reset then in_xs3=16'h4567 with in_valid pulsed, out_ready=1 -> out_valid high 4 edges after accept; out_bcd=16'h1234, out_err_mask=4'b0000, out_err=0, out_bin=1234.
- in_xs3=16'h3C0F -> out_bcd=16'h0900, out_err_mask=4'b0011, out_err=1, out_bin=900.
- Extremes: 16'hCCCC -> 16'h9999 with out_bin=9999; 16'h3333 -> 16'h0000 with out_bin=0; no errors in either case.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; a new in_valid in that window is not accepted. Releasing out_ready gives in_ready=1 on the next cycle.
- rst asserted on the 2nd CONV cycle -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0. A following word 16'h3456 decodes to 16'h0123.
- Back-to-back: in_valid held high with two words, out_ready=1 -> second accept occurs exactly NDIGITS+2 cycles after the first, and results arrive in order.
